// File: rtl/traffic_conflict_monitor.sv
// traffic_conflict_monitor: safety stage between the two-way light sequencer and the lamp drivers.
//   Checks lights_a_i/lights_b_i every cycle for illegal patterns, green/amber
//   conflicts and out-of-order moves. Legal values reach the lamps one cycle later.
//   Any violation latches a fault and flashes both lamps red until fault_clear_i.
// Ports:
//   clk            clock
//   rst            asynchronous active-high reset
//   lights_a_i     sequencer direction A {green,amber,red}
//   lights_b_i     sequencer direction B {green,amber,red}
//   fault_clear_i  1-cycle pulse that leaves FAULT
//   lamp_a_o       registered lamp drive A
//   lamp_b_o       registered lamp drive B
//   fault_o        high while in FAULT
//   fault_code_o   0 none, 1 bad pattern, 2 conflict, 3 bad sequence
//   fault_count_o  saturating count of FAULT entries
module traffic_conflict_monitor #(
   parameter int STARTUP_CYCLES = 8,
   parameter int FLASH_HALF     = 4,
   parameter int CNT_W          = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       lights_a_i,
   input  logic [2:0]       lights_b_i,
   input  logic             fault_clear_i,
   output logic [2:0]       lamp_a_o,
   output logic [2:0]       lamp_b_o,
   output logic             fault_o,
   output logic [1:0]       fault_code_o,
   output logic [CNT_W-1:0] fault_count_o
);
   localparam int SW = $clog2(STARTUP_CYCLES) + 1;
   localparam int FW = $clog2(FLASH_HALF) + 1;
   localparam logic [2:0] RED = 3'b001, RA = 3'b011, GRN = 3'b100, AMB = 3'b010, OFF = 3'b000;
   typedef enum logic [1:0] {STARTUP, NORMAL, FAULT} state_t;
   state_t state_q, state_d;
   logic [SW-1:0] cnt_q, cnt_d;
   logic [FW-1:0] fl_q, fl_d;
   logic ph_q, ph_d;
   logic [2:0] prev_a_q, prev_b_q, lamp_a_q, lamp_a_d, lamp_b_q, lamp_b_d;
   logic fault_q, fault_d;
   logic [1:0] code_q, code_d, code;
   logic [CNT_W-1:0] count_q, count_d;
   logic start_done, viol, fl_wrap, pass, dark;
   function automatic logic legal(input logic [2:0] p);
      return p inside {RED, RA, GRN, AMB};
   endfunction
   function automatic logic step_ok(input logic [2:0] p, input logic [2:0] c);
      return c == p || (p == RED && c == RA) || (p == RA && c == GRN) ||
             (p == GRN && c == AMB) || (p == AMB && c == RED);
   endfunction
   // Priority: pattern > conflict > sequence.
   assign code = (!legal(lights_a_i) || !legal(lights_b_i)) ? 2'd1 :
                 (lights_a_i != RED && lights_b_i != RED) ? 2'd2 :
                 (!step_ok(prev_a_q, lights_a_i) || !step_ok(prev_b_q, lights_b_i)) ? 2'd3 : 2'd0;
   assign viol = state_q == NORMAL && code != 2'd0;
   assign start_done = cnt_q == SW'(STARTUP_CYCLES);
   assign fl_wrap = fl_q == FW'(FLASH_HALF - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q  <= STARTUP;
         cnt_q    <= '0;
         fl_q     <= '0;
         ph_q     <= 1'b0;
         prev_a_q <= RED;
         prev_b_q <= RED;
         lamp_a_q <= RED;
         lamp_b_q <= RED;
         fault_q  <= 1'b0;
         code_q   <= 2'd0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         fl_q     <= fl_d;
         ph_q     <= ph_d;
         prev_a_q <= lights_a_i;
         prev_b_q <= lights_b_i;
         lamp_a_q <= lamp_a_d;
         lamp_b_q <= lamp_b_d;
         fault_q  <= fault_d;
         code_q   <= code_d;
         count_q  <= count_d;
      end
   always_comb begin
      state_d = state_q;
      case (state_q)
         STARTUP: if (start_done && lights_a_i == RED && lights_b_i == RED) state_d = NORMAL;
         NORMAL:  if (viol) state_d = FAULT;
         FAULT:   if (fault_clear_i) state_d = STARTUP;
         default: state_d = STARTUP;
      endcase
   end
   // Lamp values are computed for the next cycle, so the flash phase uses ph_d.
   always_comb begin
      cnt_d    = (state_q != STARTUP) ? '0 : start_done ? cnt_q : cnt_q + SW'(1);
      fl_d     = (state_q == FAULT && !fl_wrap) ? fl_q + FW'(1) : '0;
      ph_d     = (state_q == FAULT) ? ph_q ^ fl_wrap : 1'b0;
      pass     = state_q == NORMAL && !viol;
      dark     = state_q == FAULT && !fault_clear_i && ph_d;
      lamp_a_d = pass ? lights_a_i : dark ? OFF : RED;
      lamp_b_d = pass ? lights_b_i : dark ? OFF : RED;
      fault_d  = state_d == FAULT;
      code_d   = viol ? code : (state_q == FAULT && fault_clear_i) ? 2'd0 : code_q;
      count_d  = (viol && count_q != '1) ? count_q + CNT_W'(1) : count_q;
   end
   assign lamp_a_o      = lamp_a_q;
   assign lamp_b_o      = lamp_b_q;
   assign fault_o       = fault_q;
   assign fault_code_o  = code_q;
   assign fault_count_o = count_q;
endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// tb_traffic_conflict_monitor: scoreboard bench for traffic_conflict_monitor.
module tb_traffic_conflict_monitor;
   localparam int SC = 8, FH = 4, CW = 8;
   localparam logic [2:0] SEQ [4] = '{3'b011, 3'b100, 3'b010, 3'b001};
   logic clk = 1'b0, rst = 1'b1, clr = 1'b0;
   logic [2:0] la = 3'b001, lb = 3'b001, lamp_a, lamp_b;
   logic fault;
   logic [1:0] code;
   logic [CW-1:0] count;
   typedef struct packed {
      logic [2:0] a;
      logic [2:0] b;
      logic f;
      logic [1:0] c;
      logic [CW-1:0] n;
   } exp_t;
   exp_t sb [$];
   int n_chk = 0, n_err = 0;
   int m_st, m_cnt, m_k, m_n, m_c;
   logic [2:0] m_pa, m_pb;
   traffic_conflict_monitor #(.STARTUP_CYCLES(SC), .FLASH_HALF(FH), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .lights_a_i(la), .lights_b_i(lb), .fault_clear_i(clr),
      .lamp_a_o(lamp_a), .lamp_b_o(lamp_b), .fault_o(fault), .fault_code_o(code),
      .fault_count_o(count)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   function automatic bit ok_pat(input logic [2:0] p);
      return p == 3'b001 || p == 3'b011 || p == 3'b100 || p == 3'b010;
   endfunction
   function automatic bit ok_seq(input logic [2:0] p, input logic [2:0] c);
      logic [2:0] n;
      n = (p == 3'b001) ? 3'b011 : (p == 3'b011) ? 3'b100 : (p == 3'b100) ? 3'b010 : 3'b001;
      return c == p || c == n;
   endfunction
   task automatic m_reset();
      m_st = 0; m_cnt = 0; m_k = 0; m_n = 0; m_c = 0; m_pa = 3'b001; m_pb = 3'b001;
   endtask
   task automatic cyc(input logic [2:0] a, input logic [2:0] b, input logic c);
      exp_t e;
      int v;
      la = a; lb = b; clr = c;
      e.a = 3'b001; e.b = 3'b001;
      case (m_st)
         0: begin
            if (m_cnt >= SC && a == 3'b001 && b == 3'b001) m_st = 1;
            if (m_cnt < SC) m_cnt++;
         end
         1: begin
            v = (!ok_pat(a) || !ok_pat(b)) ? 1 : (a != 3'b001 && b != 3'b001) ? 2 :
                (!ok_seq(m_pa, a) || !ok_seq(m_pb, b)) ? 3 : 0;
            if (v != 0) begin
               m_st = 2; m_c = v; m_k = 0;
               if (m_n < 255) m_n++;
            end else begin
               e.a = a; e.b = b;
            end
         end
         default: begin
            if (c) begin
               m_st = 0; m_c = 0; m_cnt = 0;
            end else begin
               m_k++;
               if (((m_k / FH) % 2) == 1) begin e.a = 3'b000; e.b = 3'b000; end
            end
         end
      endcase
      m_pa = a; m_pb = b;
      e.f = m_st == 2; e.c = 2'(m_c); e.n = CW'(m_n);
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("lamp_a", 32'(lamp_a), 32'(e.a));
      chk("lamp_b", 32'(lamp_b), 32'(e.b));
      chk("fault", 32'(fault), 32'(e.f));
      chk("fault_code", 32'(code), 32'(e.c));
      chk("fault_count", 32'(count), 32'(e.n));
   endtask
   task automatic run_seq(input int periods);
      for (int i = 0; i < periods; i++)
         for (int s = 0; s < 8; s++)
            if (s < 4) cyc(3'b001, SEQ[s], 1'b0);
            else cyc(SEQ[s-4], 3'b001, 1'b0);
   endtask
   initial begin
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_lamp_a", 32'(lamp_a), 32'h1);
      chk("rst_lamp_b", 32'(lamp_b), 32'h1);
      chk("rst_fault", 32'(fault), 32'h0);
      chk("rst_code", 32'(code), 32'h0);
      chk("rst_count", 32'(count), 32'h0);
      rst = 1'b0;
      run_seq(4);
      cyc(3'b100, 3'b100, 1'b0);
      chk("conflict_code", 32'(code), 32'h2);
      repeat (10) cyc(3'b001, 3'b001, 1'b0);
      cyc(3'b100, 3'b100, 1'b1);
      chk("clear_code", 32'(code), 32'h0);
      chk("clear_count", 32'(count), 32'h1);
      run_seq(3);
      cyc(3'b101, 3'b001, 1'b0);
      chk("pattern_code", 32'(code), 32'h1);
      cyc(3'b001, 3'b001, 1'b1);
      run_seq(3);
      cyc(3'b111, 3'b100, 1'b0);
      chk("priority_code", 32'(code), 32'h1);
      cyc(3'b001, 3'b001, 1'b1);
      run_seq(3);
      cyc(3'b001, 3'b100, 1'b0);
      chk("sequence_code", 32'(code), 32'h3);
      for (int i = 0; i < 256; i++) begin
         cyc(3'b001, 3'b001, 1'b1);
         repeat (SC + 1) cyc(3'b001, 3'b001, 1'b0);
         cyc(3'b100, 3'b100, 1'b0);
      end
      chk("count_saturated", 32'(count), 32'hff);
      repeat (FH) cyc(3'b001, 3'b001, 1'b0);
      chk("flash_off_a", 32'(lamp_a), 32'h0);
      #2 rst = 1'b1;
      #1;
      chk("async_lamp_a", 32'(lamp_a), 32'h1);
      chk("async_lamp_b", 32'(lamp_b), 32'h1);
      chk("async_fault", 32'(fault), 32'h0);
      chk("async_code", 32'(code), 32'h0);
      chk("async_count", 32'(count), 32'h0);
      m_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      run_seq(3);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
